logic_gate_pipe: RTL and testbench
==================================

# logic_gate_pipe

Parametrised, registered successor to the single-bit two-input gates. Applies one of eight bitwise operations to two WIDTH-bit operands under a valid/ready handshake, with a one-entry output register. Adds a multi-beat OR-accumulate mode driven by a small state machine. Sits between any valid/ready producer and consumer as a generic logic stage.

## Interface

Parameters:
- WIDTH, 8, operand and result width (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat offered
- in_ready  out  1  block can accept a beat
- op  in  3  operation select, sampled on accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- in_last  in  1  final beat of an accumulate burst; ignored for other ops
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer accepts result
- y  out  WIDTH  result
- y_any  out  1  reduction OR of y
- y_all  out  1  reduction AND of y
- res_count  out  16  results delivered; present only with GATE_PIPE_STATS_EN

## Operation

- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational; accepting and delivering in the same cycle is allowed.
- op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 ACC_OR.
- Ops 000–110: each accepted beat loads y = f(a,b) into the output register and sets out_valid.
- FSM states: IDLE, ACC.
  - IDLE, accept with op=111, in_last=0: acc <= a|b, go to ACC, no output.
  - IDLE, accept with op=111, in_last=1: single-beat burst; y = a|b, out_valid set, stay in IDLE.
  - ACC, accept with in_last=0: acc <= acc|a|b, no output.
  - ACC, accept with in_last=1: y = acc|a|b, out_valid set, acc cleared, go to IDLE.
  - In ACC, op is ignored; every beat is treated as ACC_OR until in_last.
- A non-last ACC beat may be accepted while out_valid=1 only if in_ready=1; back-pressure applies uniformly to all beats.
- y_any = |y, y_all = &y. Both are combinational from the output register.
- Unaccepted beats have no effect on state, acc or outputs.

## Timing

- Latency: the result is visible on y with out_valid=1 in the cycle after the accepting edge.
- Throughput: one beat per cycle when out_ready is held at 1.
- out_valid stays high and y stays stable until delivery.
- Reset values: out_valid=0, y=0, y_any=0, y_all=0, acc=0, state=IDLE, res_count=0. in_ready is therefore 1 after reset.
- rst during an ACC burst discards acc and any pending result.
- rst overrides a same-cycle accept or deliver.

## Configuration

- GATE_PIPE_STATS_EN defined: adds the res_count port.
  - Increments by 1 on each deliver and saturates at 16'hFFFF.
  - Cleared by rst.
- GATE_PIPE_STATS_EN undefined: the res_count port and its counter do not exist; all other behaviour is identical.

## Test plan

- Reset, then op=001, a=8'hF0, b=8'h0F, out_ready=1 → next cycle: y=8'hFF, out_valid=1, y_all=1, y_any=1.
- Sweep ops 000–110 with a=8'hCA, b=8'h5C → y = 48, DE, 96, B7, 21, 69, 35 respectively, one result per cycle, no bubbles.
- Hold out_ready=0 after one result (op=000, a=8'hFF, b=8'h01): y=8'h01 stays stable, in_ready=0, the second offered beat is not accepted. Raise out_ready → the second beat is accepted in that same cycle.
- ACC_OR burst of beats (01,02), (04,00), (00,80) with last on the third beat → a single result y=8'h87. No out_valid during beats 1–2. A burst sent with op=000 on beats 2–3 gives the same result.
- Assert rst mid-burst after beat 1, then run a new single-beat burst (10,00,last) → y=8'h10, with no stale bits carried over.
- With GATE_PIPE_STATS_EN: 5 delivered results → res_count=5; preload near saturation (force or long run) → count holds at 16'hFFFF.

Source files
------------

// File: rtl/logic_gate_pipe_if.sv
// logic_gate_pipe_if: valid/ready bus of the generic logic stage.
// The master side is the traffic source and sink around the stage.
// The slave side is the stage itself.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_any;
  logic             y_all;

  modport master (
    output in_valid, op, a, b, in_last, out_ready,
    input  in_ready, out_valid, y, y_any, y_all
  );

  modport slave (
    input  in_valid, op, a, b, in_last, out_ready,
    output in_ready, out_valid, y, y_any, y_all
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered bitwise gate stage with a valid/ready handshake,
// a one-entry output register and a multi-beat OR-accumulate mode (op 111).
// Optional feature macro: GATE_PIPE_STATS_EN adds the res_count port, a
// saturating 16-bit count of delivered results.
module logic_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef GATE_PIPE_STATS_EN
  logic_gate_pipe_if.slave     bus,
  output logic [15:0]          res_count
`else
  logic_gate_pipe_if.slave     bus
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             deliver;
  logic             acc_beat;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle combinational gate evaluation for ops 000-110.
  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] opa,
    input logic [WIDTH-1:0] opb
  );
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = opa & opb;
      OP_OR:   r = opa | opb;
      OP_XOR:  r = opa ^ opb;
      OP_NAND: r = ~(opa & opb);
      OP_NOR:  r = ~(opa | opb);
      OP_XNOR: r = ~(opa ^ opb);
      OP_NOTA: r = ~opa;
      default: r = opa | opb;
    endcase
    return r;
  endfunction

  // The output register can take a new beat whenever it is empty or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign deliver      = out_valid_q && bus.out_ready;

  // Inside a burst every beat accumulates regardless of op.
  assign acc_beat = (state_q == ACC) || (bus.op == OP_ACC);
  assign acc_sum  = ((state_q == ACC) ? acc_q : '0) | bus.a | bus.b;

  // Next-state logic for the FSM, accumulator and output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (deliver) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (acc_beat) begin
        if (bus.in_last) begin
          y_d         = acc_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = IDLE;
        end else begin
          acc_d   = acc_sum;
          state_d = ACC;
        end
      end else begin
        y_d         = gate_eval(bus.op, bus.a, bus.b);
        out_valid_d = 1'b1;
      end
    end
  end

  // State, accumulator and output register; reset discards any burst or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_any     = |y_q;
  assign bus.y_all     = &y_q;

`ifdef GATE_PIPE_STATS_EN
  logic [15:0] res_count_q, res_count_d;

  // Delivered-result counter, sticks at all-ones instead of wrapping.
  always_comb begin
    res_count_d = res_count_q;
    if (deliver && (res_count_q != 16'hFFFF)) begin
      res_count_d = res_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_count_q <= 16'd0;
    end else begin
      res_count_q <= res_count_d;
    end
  end

  assign res_count = res_count_q;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: table-driven vectors plus hand-written multi-cycle sequences.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic_gate_pipe_if #(.WIDTH(8)) bus ();

`ifdef GATE_PIPE_STATS_EN
  logic [15:0] res_count;
  logic_gate_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .res_count (res_count)
  );
`else
  logic_gate_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic       exp_vld;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic last, input logic ev, input logic [7:0] ey);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.last = last; v.exp_vld = ev; v.exp_y = ey;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic last);
    bus.in_valid = v; bus.op = op; bus.a = a; bus.b = b; bus.in_last = last;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(3'b001, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'hFF);
    vecs[1]  = mk(3'b000, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'h48);
    vecs[2]  = mk(3'b001, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'hDE);
    vecs[3]  = mk(3'b010, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'h96);
    vecs[4]  = mk(3'b011, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'hB7);
    vecs[5]  = mk(3'b100, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'h21);
    vecs[6]  = mk(3'b101, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'h69);
    vecs[7]  = mk(3'b110, 8'hCA, 8'h5C, 1'b0, 1'b1, 8'h35);
    vecs[8]  = mk(3'b111, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00);
    vecs[9]  = mk(3'b111, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[10] = mk(3'b111, 8'h00, 8'h80, 1'b1, 1'b1, 8'h87);
    vecs[11] = mk(3'b111, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00);
    vecs[12] = mk(3'b000, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[13] = mk(3'b000, 8'h00, 8'h80, 1'b1, 1'b1, 8'h87);
    vecs[14] = mk(3'b111, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10);
    vecs[15] = mk(3'b000, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h00);
    vecs[16] = mk(3'b101, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF);
    vecs[17] = mk(3'b110, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    vecs[18] = mk(3'b100, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF);

    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_y",         32'(bus.y),         32'd0);
    chk("reset_y_any",     32'(bus.y_any),     32'd0);
    chk("reset_y_all",     32'(bus.y_all),     32'd0);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
`ifdef GATE_PIPE_STATS_EN
    chk("reset_res_count", 32'(res_count), 32'd0);
`endif

    // Back-to-back table, one beat per cycle with the consumer always ready.
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].last);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        chk($sformatf("vec%0d_y", i),     32'(bus.y),     32'(vecs[i].exp_y));
        chk($sformatf("vec%0d_y_any", i), 32'(bus.y_any), 32'(|vecs[i].exp_y));
        chk($sformatf("vec%0d_y_all", i), 32'(bus.y_all), 32'(&vecs[i].exp_y));
      end
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Back-pressure: result held, second beat waits, accepted on the release cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b000, 8'hFF, 8'h01, 1'b0);
    tick();
    chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_first_y",     32'(bus.y),         32'h01);
    drive(1'b1, 3'b001, 8'h10, 8'h20, 1'b0);
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_hold_y1", 32'(bus.y),         32'h01);
    chk("bp_hold_v1", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_hold_y2", 32'(bus.y), 32'h01);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_second_y",     32'(bus.y),         32'h30);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a burst drops the partial accumulation.
    drive(1'b1, 3'b111, 8'h01, 8'h00, 1'b0);
    tick();
    chk("rb_beat1_no_out", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_after_rst_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 3'b111, 8'h10, 8'h00, 1'b1);
    tick();
    chk("rb_new_valid", 32'(bus.out_valid), 32'd1);
    chk("rb_new_y",     32'(bus.y),         32'h10);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    tick();

    // Reset discards a result held under back-pressure.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b101, 8'hFF, 8'hFF, 1'b0);
    tick();
    chk("rp_pending_y", 32'(bus.y), 32'hFF);
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rp_valid_cleared", 32'(bus.out_valid), 32'd0);
    chk("rp_y_cleared",     32'(bus.y),         32'd0);
    chk("rp_y_all_cleared", 32'(bus.y_all),     32'd0);
    bus.out_ready = 1'b1;

`ifdef GATE_PIPE_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_cleared", 32'(res_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'b010, 8'(k), 8'h00, 1'b0);
      tick();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    tick();
    chk("st_count5", 32'(res_count), 32'd5);
    force dut.res_count_q = 16'hFFFE;
    #1;
    release dut.res_count_q;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b0);
      tick();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
    tick();
    chk("st_saturated", 32'(res_count), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
